// File: rtl/rr_merge_4_1.sv
// Round-robin 4-to-1 stream merger.
// Four valid/ready input channels of 4-bit words are merged into one
// registered output stream tagged with the source channel index. The grant
// rotates so that the channel after the last one served gets first
// priority. in_ready is combinational; out_valid, out_data and out_id come
// straight from flops.

// Plain 4-way word selector used for the merge data path.
module mux_4_1 (
    input  logic [1:0] sel,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic [3:0] y
);

    // Select one of the four channel words.
    always_comb begin
        y = 4'd0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = 4'd0;
        endcase
    end

endmodule

module rr_merge_4_1 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_valid,
    output logic [3:0] in_ready,
    input  logic [3:0] in_data0,
    input  logic [3:0] in_data1,
    input  logic [3:0] in_data2,
    input  logic [3:0] in_data3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [1:0] out_id
);

    // Output register and priority pointer.
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_data_q,  out_data_d;
    logic [1:0] out_id_q,    out_id_d;
    logic [1:0] ptr_q,       ptr_d;

    // Arbitration signals.
    logic [3:0] rot_valid_s;     // in_valid rotated so bit 0 is channel ptr
    logic [1:0] offset_s;        // distance from ptr to the winning channel
    logic       grant_valid_s;
    logic [1:0] grant_idx_s;
    logic       load_s;
    logic [3:0] mux_data_s;
    logic [3:0] in_ready_s;

    // The output slot can take a new word when empty or when it drains now.
    assign load_s = !out_valid_q || out_ready;

    // Rotate the request vector so the highest-priority channel sits at bit 0.
    always_comb begin
        rot_valid_s = in_valid;
        case (ptr_q)
            2'd0:    rot_valid_s = in_valid;
            2'd1:    rot_valid_s = {in_valid[0],   in_valid[3:1]};
            2'd2:    rot_valid_s = {in_valid[1:0], in_valid[3:2]};
            2'd3:    rot_valid_s = {in_valid[2:0], in_valid[3]};
            default: rot_valid_s = in_valid;
        endcase
    end

    // Fixed-priority pick on the rotated vector, mapped back to a channel.
    always_comb begin
        offset_s      = 2'd0;
        grant_valid_s = 1'b1;
        if (rot_valid_s[0]) begin
            offset_s = 2'd0;
        end else if (rot_valid_s[1]) begin
            offset_s = 2'd1;
        end else if (rot_valid_s[2]) begin
            offset_s = 2'd2;
        end else if (rot_valid_s[3]) begin
            offset_s = 2'd3;
        end else begin
            offset_s      = 2'd0;
            grant_valid_s = 1'b0;
        end
    end

    // Two-bit addition wraps naturally, giving (ptr + offset) mod 4.
    assign grant_idx_s = ptr_q + offset_s;

    mux_4_1 u_mux (
        .sel (grant_idx_s),
        .d0  (in_data0),
        .d1  (in_data1),
        .d2  (in_data2),
        .d3  (in_data3),
        .y   (mux_data_s)
    );

    // Handshake back to the granted channel only; silent during reset.
    always_comb begin
        in_ready_s = 4'b0000;
        if (!rst && load_s && grant_valid_s) begin
            case (grant_idx_s)
                2'd0:    in_ready_s = 4'b0001;
                2'd1:    in_ready_s = 4'b0010;
                2'd2:    in_ready_s = 4'b0100;
                2'd3:    in_ready_s = 4'b1000;
                default: in_ready_s = 4'b0000;
            endcase
        end else begin
            in_ready_s = 4'b0000;
        end
    end

    assign in_ready = in_ready_s;

    // Next state: load a granted word, empty the slot when idle, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (load_s) begin
            if (grant_valid_s) begin
                out_valid_d = 1'b1;
                out_data_d  = mux_data_s;
                out_id_d    = grant_idx_s;
                ptr_d       = grant_idx_s + 2'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset that discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 4'd0;
            out_id_q    <= 2'd0;
            ptr_q       <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_merge_4_1.sv
// Scoreboard bench for rr_merge_4_1: directed scenarios followed by random
// traffic, checked against a behavioural round-robin model.
module tb_rr_merge_4_1;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_id;

    rr_merge_4_1 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int         m_ptr   = 0;
    bit         m_full  = 1'b0;
    int         m_hid   = 0;
    int         m_hdata = 0;
    int         exp_q[$];          // expected words, encoded id*16 + data

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got id=%0d data=%0d expected none", out_id, out_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("out_id",   int'(out_id),   e / 16);
                chk("out_data", int'(out_data), e % 16);
            end
        end
    end

    // One clock cycle: drive inputs after the edge, check and advance the model.
    task automatic cycle(input logic r, input logic [3:0] v, input logic [15:0] d,
                         input logic rdy);
        int  exp_rdy;
        int  g;
        bit  found;
        bit  load;
        @(posedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        in_data0  = d[3:0];
        in_data1  = d[7:4];
        in_data2  = d[11:8];
        in_data3  = d[15:12];
        out_ready = rdy;
        @(negedge clk);
        #1;
        // Registered outputs reflect the model after the previous edge.
        chk("out_valid", int'(out_valid), int'(m_full));
        chk("hold_id",   int'(out_id),    m_hid);
        chk("hold_data", int'(out_data),  m_hdata);
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < 4; k++) begin
            if (!found && v[(m_ptr + k) % 4]) begin
                found = 1'b1;
                g     = (m_ptr + k) % 4;
            end
        end
        load    = !m_full || rdy;
        exp_rdy = (!r && load && found) ? (1 << g) : 0;
        chk("in_ready", int'(in_ready), exp_rdy);
        if (r) begin
            m_full  = 1'b0;
            m_ptr   = 0;
            m_hid   = 0;
            m_hdata = 0;
            exp_q.delete();
        end else if (load) begin
            if (found) begin
                m_hid   = g;
                m_hdata = int'(d[4*g +: 4]);
                exp_q.push_back(m_hid * 16 + m_hdata);
                m_full  = 1'b1;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_full = 1'b0;
            end
        end
    endtask

    localparam logic [15:0] ABCD = 16'hD_C_B_A;   // channel i carries A+i

    initial begin
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        in_data0 = 4'd0; in_data1 = 4'd0; in_data2 = 4'd0; in_data3 = 4'd0;

        // Reset, then idle with the consumer ready.
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1);
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1);
        repeat (3) cycle(1'b0, 4'b0000, 16'h0000, 1'b1);

        // Single channel 2 carrying 9; pointer moves to 3.
        cycle(1'b0, 4'b0100, 16'h0900, 1'b1);
        cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
        cycle(1'b0, 4'b0000, 16'h0000, 1'b1);

        // Fairness from reset: 0,1,2,3,0.
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1);
        repeat (5) cycle(1'b0, 4'b1111, ABCD, 1'b1);
        cycle(1'b0, 4'b0000, ABCD, 1'b1);

        // Backpressure while holding (1,b), then release and grant channel 2.
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1);
        cycle(1'b0, 4'b1111, ABCD, 1'b1);
        cycle(1'b0, 4'b1111, ABCD, 1'b1);
        repeat (4) cycle(1'b0, 4'b1111, ABCD, 1'b0);
        cycle(1'b0, 4'b1111, ABCD, 1'b1);

        // Wrap and skip: pointer is 3, channels 0 and 1 valid.
        repeat (3) cycle(1'b0, 4'b0011, ABCD, 1'b1);
        cycle(1'b0, 4'b0000, ABCD, 1'b1);

        // Reset while (2,c) is held, then restart at channel 0.
        cycle(1'b1, 4'b0000, 16'h0000, 1'b1);
        repeat (3) cycle(1'b0, 4'b1111, ABCD, 1'b1);
        cycle(1'b1, 4'b1111, ABCD, 1'b0);
        cycle(1'b0, 4'b1111, ABCD, 1'b1);
        cycle(1'b0, 4'b0000, ABCD, 1'b1);

        // Random traffic with occasional resets and stalls.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                  4'($urandom_range(0, 15)),
                  16'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        // Drain the output register and confirm nothing is left over.
        repeat (3) cycle(1'b0, 4'b0000, 16'h0000, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
